// File: rtl/memory_access_if.sv
// MEM-stage bus bundle: EX/MEM-side control and data in, MEM/WB pipeline outputs back.
// The master side belongs to the upstream pipeline; memory_access uses the slave side.
interface memory_access_if #(
    parameter int NB_DATA = 32
);
    logic               i_stall;
    logic               i_halt;
    logic               i_mem2reg;
    logic               i_memRead;
    logic               i_memWrite;
    logic               i_regWrite;
    logic [1:0]         i_mem_width;
    logic               i_unsigned;
    logic [NB_DATA-1:0] i_result;
    logic [NB_DATA-1:0] i_store_data;
    logic [4:0]         i_write_reg;

    logic               o_regWrite;
    logic               o_mem2reg;
    logic [4:0]         o_write_reg;
    logic [NB_DATA-1:0] o_wb_data;
    logic               o_misaligned;
    logic               o_halted;

    modport master (
        output i_stall, i_halt, i_mem2reg, i_memRead, i_memWrite, i_regWrite,
               i_mem_width, i_unsigned, i_result, i_store_data, i_write_reg,
        input  o_regWrite, o_mem2reg, o_write_reg, o_wb_data, o_misaligned, o_halted
    );

    modport slave (
        input  i_stall, i_halt, i_mem2reg, i_memRead, i_memWrite, i_regWrite,
               i_mem_width, i_unsigned, i_result, i_store_data, i_write_reg,
        output o_regWrite, o_mem2reg, o_write_reg, o_wb_data, o_misaligned, o_halted
    );
endinterface

// File: rtl/memory_access.sv
// MIPS MEM stage: little-endian byte-organised data memory plus the MEM/WB register.
// Optional MEM_DEBUG_PORT_EN adds a registered word-read port for post-halt memory dumps.
module memory_access #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_rst,
    memory_access_if.slave     bus
`ifdef MEM_DEBUG_PORT_EN
    ,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data
`endif
);

    localparam int DEPTH = 1 << NB_ADDR;

    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_WORD = 2'b10,
        W_RSVD = 2'b11
    } width_e;

    logic [7:0]         r_mem [DEPTH];

    logic               r_regWrite;
    logic               r_mem2reg;
    logic [4:0]         r_write_reg;
    logic [NB_DATA-1:0] r_wb_data;
    logic               r_misaligned;
    logic               r_halted;

    width_e             w_width;
    logic [NB_ADDR-1:0] w_idx0;
    logic [NB_ADDR-1:0] w_idx1;
    logic [NB_ADDR-1:0] w_idx2;
    logic [NB_ADDR-1:0] w_idx3;
    logic               w_align_err;
    logic               w_misaligned;
    logic               w_mis_load;
    logic               w_freeze;
    logic               w_store;
    logic [NB_DATA-1:0] w_rd_word;
    logic [NB_DATA-1:0] w_load_data;
    logic [NB_DATA-1:0] w_wb_next;
    logic               w_unused;

    assign w_width  = width_e'(bus.i_mem_width);
    assign w_idx0   = bus.i_result[NB_ADDR-1:0];
    assign w_idx1   = w_idx0 + NB_ADDR'(1);
    assign w_idx2   = w_idx0 + NB_ADDR'(2);
    assign w_idx3   = w_idx0 + NB_ADDR'(3);
    assign w_unused = ^bus.i_result[NB_DATA-1:NB_ADDR];

    // Reserved width encoding behaves as a word access everywhere.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_align_err = 1'b0;
        case (w_width)
            W_BYTE:  w_align_err = 1'b0;
            W_HALF:  w_align_err = w_idx0[0];
            default: w_align_err = |w_idx0[1:0];
        endcase
    end

    assign w_misaligned = (bus.i_memRead | bus.i_memWrite) & w_align_err;
    assign w_mis_load   = bus.i_memRead & w_align_err;
    assign w_freeze     = bus.i_stall | bus.i_halt;
    assign w_store      = bus.i_memWrite & ~w_align_err & ~w_freeze;

    // Reads see the array before this edge's store, giving read-before-write ordering.
    assign w_rd_word = {r_mem[w_idx3], r_mem[w_idx2], r_mem[w_idx1], r_mem[w_idx0]};

    always_comb begin
        w_load_data = '0;
        if (bus.i_memRead && !w_align_err) begin
            case (w_width)
                W_BYTE: w_load_data = bus.i_unsigned
                                    ? {{(NB_DATA-8){1'b0}}, w_rd_word[7:0]}
                                    : {{(NB_DATA-8){w_rd_word[7]}}, w_rd_word[7:0]};
                W_HALF: w_load_data = bus.i_unsigned
                                    ? {{(NB_DATA-16){1'b0}}, w_rd_word[15:0]}
                                    : {{(NB_DATA-16){w_rd_word[15]}}, w_rd_word[15:0]};
                default: w_load_data = w_rd_word;
            endcase
        end
    end

    assign w_wb_next = bus.i_mem2reg ? w_load_data : bus.i_result;

    // NOTE: the data memory is cleared on reset, so it is built from resettable flops
    // rather than a RAM macro; a plain RAM would need a separate clear sequence.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_store) begin
            r_mem[w_idx0] <= bus.i_store_data[7:0];
            if (w_width != W_BYTE) begin
                r_mem[w_idx1] <= bus.i_store_data[15:8];
            end
            if (w_width == W_WORD || w_width == W_RSVD) begin
                r_mem[w_idx2] <= bus.i_store_data[23:16];
                r_mem[w_idx3] <= bus.i_store_data[31:24];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_regWrite   <= 1'b0;
            r_mem2reg    <= 1'b0;
            r_write_reg  <= '0;
            r_wb_data    <= '0;
            r_misaligned <= 1'b0;
        end else if (!w_freeze) begin
            r_regWrite   <= bus.i_regWrite & ~w_mis_load;
            r_mem2reg    <= bus.i_mem2reg;
            r_write_reg  <= bus.i_write_reg;
            r_wb_data    <= w_wb_next;
            r_misaligned <= w_misaligned;
        end
    end

    // Sticky until reset so the debug unit can see the core stopped even after i_halt drops.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_halted <= 1'b0;
        end else if (bus.i_halt) begin
            r_halted <= 1'b1;
        end
    end

    assign bus.o_regWrite   = r_regWrite;
    assign bus.o_mem2reg    = r_mem2reg;
    assign bus.o_write_reg  = r_write_reg;
    assign bus.o_wb_data    = r_wb_data;
    assign bus.o_misaligned = r_misaligned;
    assign bus.o_halted     = r_halted;

`ifdef MEM_DEBUG_PORT_EN
    logic [NB_ADDR-1:0] w_dbg_base;
    logic [NB_DATA-1:0] r_dbg_data;
    logic               w_unused_dbg;

    assign w_dbg_base   = {i_dbg_addr[NB_ADDR-1:2], 2'b00};
    assign w_unused_dbg = ^i_dbg_addr[1:0];

    // Runs through stall and halt; it only observes the array.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= {r_mem[w_dbg_base | NB_ADDR'(3)], r_mem[w_dbg_base | NB_ADDR'(2)],
                           r_mem[w_dbg_base | NB_ADDR'(1)], r_mem[w_dbg_base]};
        end
    end

    assign o_dbg_data = r_dbg_data;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Directed-vector bench for memory_access (default build, debug port disabled).
// Each scenario task drives its own stimulus and compares against hand-computed values.
module tb_memory_access;

    logic clk;
    logic i_rst;
    int   n_vec;
    int   n_err;

    memory_access_if #(.NB_DATA(32)) bus ();

    memory_access #(
        .NB_DATA(32),
        .NB_ADDR(8)
    ) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one instruction, then sample 1 ns after the rising edge.
    task automatic apply(input logic rd, input logic wr, input logic [1:0] w,
                         input logic uns, input logic m2r, input logic rw,
                         input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] wreg);
        bus.i_memRead    = rd;
        bus.i_memWrite   = wr;
        bus.i_mem_width  = w;
        bus.i_unsigned   = uns;
        bus.i_mem2reg    = m2r;
        bus.i_regWrite   = rw;
        bus.i_result     = res;
        bus.i_store_data = sd;
        bus.i_write_reg  = wreg;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        bus.i_halt = 1'b0;
        bus.i_stall = 1'b0;
        apply(1, 0, 2'b10, 0, 1, 1, 32'h10, 32'h0, 5'd9);
        apply(1, 0, 2'b10, 0, 1, 1, 32'h10, 32'h0, 5'd9);
        n_vec++;
        if (bus.o_wb_data !== 32'h0) begin
            n_err++; $display("FAIL reset_wb_data: got %h want %h", bus.o_wb_data, 32'h0);
        end
        n_vec++;
        if ({bus.o_regWrite, bus.o_mem2reg, bus.o_misaligned, bus.o_halted} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b want 0000",
                              {bus.o_regWrite, bus.o_mem2reg, bus.o_misaligned, bus.o_halted});
        end
        n_vec++;
        if (bus.o_write_reg !== 5'd0) begin
            n_err++; $display("FAIL reset_write_reg: got %0d want 0", bus.o_write_reg);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_word;
        apply(0, 1, 2'b10, 0, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        n_vec++;
        if (bus.o_wb_data !== 32'h10 || bus.o_regWrite !== 1'b0) begin
            n_err++; $display("FAIL sw_outputs: got wb=%h rw=%b want wb=00000010 rw=0",
                              bus.o_wb_data, bus.o_regWrite);
        end
        apply(1, 0, 2'b10, 0, 1, 1, 32'h10, 32'h0, 5'd5);
        n_vec++;
        if (bus.o_wb_data !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL lw_data: got %h want deadbeef", bus.o_wb_data);
        end
        n_vec++;
        if (bus.o_write_reg !== 5'd5 || bus.o_regWrite !== 1'b1 || bus.o_mem2reg !== 1'b1) begin
            n_err++; $display("FAIL lw_ctrl: got rd=%0d rw=%b m2r=%b want rd=5 rw=1 m2r=1",
                              bus.o_write_reg, bus.o_regWrite, bus.o_mem2reg);
        end
        // Load data must be zero when memRead is low even with mem2reg set.
        apply(0, 0, 2'b10, 0, 1, 1, 32'h10, 32'h0, 5'd5);
        n_vec++;
        if (bus.o_wb_data !== 32'h0) begin
            n_err++; $display("FAIL noread_data: got %h want 00000000", bus.o_wb_data);
        end
    endtask

    task automatic test_byte_half;
        apply(0, 1, 2'b00, 0, 0, 0, 32'h21, 32'h12345680, 5'd0);
        apply(1, 0, 2'b00, 0, 1, 1, 32'h21, 32'h0, 5'd6);
        n_vec++;
        if (bus.o_wb_data !== 32'hFFFFFF80 || bus.o_misaligned !== 1'b0) begin
            n_err++; $display("FAIL lb_signed: got %h mis=%b want ffffff80 mis=0",
                              bus.o_wb_data, bus.o_misaligned);
        end
        apply(1, 0, 2'b00, 1, 1, 1, 32'h21, 32'h0, 5'd6);
        n_vec++;
        if (bus.o_wb_data !== 32'h00000080) begin
            n_err++; $display("FAIL lbu: got %h want 00000080", bus.o_wb_data);
        end
        apply(1, 0, 2'b01, 0, 1, 1, 32'h20, 32'h0, 5'd6);
        n_vec++;
        if (bus.o_wb_data !== 32'hFFFF8000) begin
            n_err++; $display("FAIL lh_signed: got %h want ffff8000", bus.o_wb_data);
        end
        apply(1, 0, 2'b01, 1, 1, 1, 32'h20, 32'h0, 5'd6);
        n_vec++;
        if (bus.o_wb_data !== 32'h00008000) begin
            n_err++; $display("FAIL lhu: got %h want 00008000", bus.o_wb_data);
        end
        // Little-endian packing across a half store and a word load.
        apply(0, 1, 2'b01, 0, 0, 0, 32'h22, 32'h9999A1B2, 5'd0);
        apply(1, 0, 2'b10, 0, 1, 1, 32'h20, 32'h0, 5'd6);
        n_vec++;
        if (bus.o_wb_data !== 32'hA1B28000) begin
            n_err++; $display("FAIL endian_word: got %h want a1b28000", bus.o_wb_data);
        end
    endtask

    task automatic test_misaligned;
        apply(1, 0, 2'b10, 0, 1, 1, 32'h13, 32'h0, 5'd7);
        n_vec++;
        if (bus.o_misaligned !== 1'b1 || bus.o_wb_data !== 32'h0 || bus.o_regWrite !== 1'b0) begin
            n_err++; $display("FAIL lw_misaligned: got mis=%b wb=%h rw=%b want mis=1 wb=0 rw=0",
                              bus.o_misaligned, bus.o_wb_data, bus.o_regWrite);
        end
        apply(0, 1, 2'b01, 0, 0, 0, 32'h13, 32'h0000FFFF, 5'd0);
        n_vec++;
        if (bus.o_misaligned !== 1'b1) begin
            n_err++; $display("FAIL sh_misaligned_flag: got %b want 1", bus.o_misaligned);
        end
        apply(1, 0, 2'b01, 1, 1, 1, 32'h12, 32'h0, 5'd7);
        n_vec++;
        if (bus.o_wb_data !== 32'h0000DEAD || bus.o_misaligned !== 1'b0) begin
            n_err++; $display("FAIL sh_misaligned_mem: got %h mis=%b want 0000dead mis=0",
                              bus.o_wb_data, bus.o_misaligned);
        end
        apply(1, 0, 2'b10, 0, 1, 1, 32'h10, 32'h0, 5'd7);
        n_vec++;
        if (bus.o_wb_data !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL sh_misaligned_word: got %h want deadbeef", bus.o_wb_data);
        end
    endtask

    task automatic test_stall;
        apply(0, 0, 2'b10, 0, 0, 1, 32'hAAAA, 32'h0, 5'd7);
        bus.i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 2'b10, 0, 0, 0, 32'h30, 32'h55, 5'd9);
            n_vec++;
            if (bus.o_wb_data !== 32'hAAAA || bus.o_write_reg !== 5'd7 || bus.o_regWrite !== 1'b1) begin
                n_err++; $display("FAIL stall_hold[%0d]: got wb=%h rd=%0d rw=%b want wb=0000aaaa rd=7 rw=1",
                                  i, bus.o_wb_data, bus.o_write_reg, bus.o_regWrite);
            end
        end
        bus.i_stall = 1'b0;
        apply(1, 0, 2'b10, 0, 1, 1, 32'h30, 32'h0, 5'd8);
        n_vec++;
        if (bus.o_wb_data !== 32'h0) begin
            n_err++; $display("FAIL stall_no_store: got %h want 00000000", bus.o_wb_data);
        end
        apply(0, 1, 2'b10, 0, 0, 0, 32'h30, 32'h55, 5'd9);
        n_vec++;
        if (bus.o_wb_data !== 32'h30 || bus.o_write_reg !== 5'd9 || bus.o_regWrite !== 1'b0) begin
            n_err++; $display("FAIL stall_release: got wb=%h rd=%0d rw=%b want wb=00000030 rd=9 rw=0",
                              bus.o_wb_data, bus.o_write_reg, bus.o_regWrite);
        end
        apply(1, 0, 2'b10, 0, 1, 1, 32'h30, 32'h0, 5'd8);
        n_vec++;
        if (bus.o_wb_data !== 32'h55) begin
            n_err++; $display("FAIL stall_commit: got %h want 00000055", bus.o_wb_data);
        end
    endtask

    task automatic test_rtype_alias;
        apply(0, 0, 2'b10, 0, 0, 1, 32'h1234, 32'h0, 5'd3);
        n_vec++;
        if (bus.o_wb_data !== 32'h1234 || bus.o_regWrite !== 1'b1 || bus.o_write_reg !== 5'd3) begin
            n_err++; $display("FAIL rtype: got wb=%h rw=%b rd=%0d want wb=00001234 rw=1 rd=3",
                              bus.o_wb_data, bus.o_regWrite, bus.o_write_reg);
        end
        apply(0, 0, 2'b10, 0, 0, 1, 32'h1, 32'h0, 5'd0);
        n_vec++;
        if (bus.o_regWrite !== 1'b1 || bus.o_write_reg !== 5'd0) begin
            n_err++; $display("FAIL write_r0: got rw=%b rd=%0d want rw=1 rd=0",
                              bus.o_regWrite, bus.o_write_reg);
        end
        apply(0, 1, 2'b10, 0, 0, 0, 32'h0, 32'hCAFEF00D, 5'd0);
        apply(1, 0, 2'b10, 0, 1, 1, 32'h100, 32'h0, 5'd2);
        n_vec++;
        if (bus.o_wb_data !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL alias_read: got %h want cafef00d", bus.o_wb_data);
        end
        apply(0, 1, 2'b00, 0, 0, 0, 32'h1F01, 32'h000000EE, 5'd0);
        apply(1, 0, 2'b10, 0, 1, 1, 32'h0, 32'h0, 5'd2);
        n_vec++;
        if (bus.o_wb_data !== 32'hCAFEEE0D) begin
            n_err++; $display("FAIL alias_write: got %h want cafeee0d", bus.o_wb_data);
        end
    endtask

    task automatic test_halt_reset;
        apply(0, 0, 2'b10, 0, 0, 1, 32'h0BAD, 32'h0, 5'd4);
        bus.i_halt = 1'b1;
        apply(0, 1, 2'b10, 0, 0, 0, 32'h40, 32'h77, 5'd6);
        n_vec++;
        if (bus.o_halted !== 1'b1 || bus.o_wb_data !== 32'h0BAD || bus.o_write_reg !== 5'd4) begin
            n_err++; $display("FAIL halt_hold: got h=%b wb=%h rd=%0d want h=1 wb=00000bad rd=4",
                              bus.o_halted, bus.o_wb_data, bus.o_write_reg);
        end
        bus.i_halt = 1'b0;
        apply(0, 0, 2'b10, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        n_vec++;
        if (bus.o_halted !== 1'b1 || bus.o_wb_data !== 32'h0) begin
            n_err++; $display("FAIL halt_sticky: got h=%b wb=%h want h=1 wb=00000000",
                              bus.o_halted, bus.o_wb_data);
        end
        apply(1, 0, 2'b10, 0, 1, 1, 32'h40, 32'h0, 5'd6);
        n_vec++;
        if (bus.o_wb_data !== 32'h0) begin
            n_err++; $display("FAIL halt_no_store: got %h want 00000000", bus.o_wb_data);
        end
        bus.i_stall = 1'b1;
        bus.i_halt  = 1'b1;
        apply(0, 0, 2'b10, 0, 0, 1, 32'h5A5A, 32'h0, 5'd1);
        n_vec++;
        if (bus.o_halted !== 1'b1 || bus.o_wb_data !== 32'h0 || bus.o_write_reg !== 5'd6) begin
            n_err++; $display("FAIL stall_halt: got h=%b wb=%h rd=%0d want h=1 wb=0 rd=6",
                              bus.o_halted, bus.o_wb_data, bus.o_write_reg);
        end
        i_rst = 1'b1;
        apply(1, 0, 2'b10, 0, 1, 1, 32'h10, 32'h0, 5'd5);
        n_vec++;
        if (bus.o_halted !== 1'b0 || bus.o_regWrite !== 1'b0 || bus.o_write_reg !== 5'd0 ||
            bus.o_wb_data !== 32'h0) begin
            n_err++; $display("FAIL reset_over_halt: got h=%b rw=%b rd=%0d wb=%h want all 0",
                              bus.o_halted, bus.o_regWrite, bus.o_write_reg, bus.o_wb_data);
        end
        i_rst = 1'b0;
        bus.i_stall = 1'b0;
        bus.i_halt  = 1'b0;
        apply(1, 0, 2'b10, 0, 1, 1, 32'h10, 32'h0, 5'd5);
        n_vec++;
        if (bus.o_wb_data !== 32'h0 || bus.o_regWrite !== 1'b1 || bus.o_write_reg !== 5'd5) begin
            n_err++; $display("FAIL reset_mem_clear: got wb=%h rw=%b rd=%0d want wb=0 rw=1 rd=5",
                              bus.o_wb_data, bus.o_regWrite, bus.o_write_reg);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        i_rst = 1'b1;
        bus.i_stall = 1'b0;
        bus.i_halt  = 1'b0;
        test_reset();
        test_word();
        test_byte_half();
        test_misaligned();
        test_stall();
        test_rtype_alias();
        test_halt_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM stage of the 5-stage MIPS pipeline. Receives the EX/MEM-side control and ALU result from instruction_execute.
- Performs byte/half/word loads and stores against an internal synchronous data memory.
- Registers the MEM/WB pipeline outputs consumed by writeback and the forwarding unit.

Parameters:
- NB_DATA, 32, datapath width (bits); must be 32 for half/word access.
- NB_ADDR, 8, byte-address bits used to index memory; depth = 2^NB_ADDR bytes.

Ports:
- clk  in  1  clock; all state on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_stall  in  1  hold MEM/WB register, suppress store.
- i_halt  in  1  freeze stage (as stall) and set o_halted.
- i_mem2reg  in  1  writeback selects load data.
- i_memRead  in  1  load enable.
- i_memWrite  in  1  store enable.
- i_regWrite  in  1  writeback enable.
- i_mem_width  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- i_unsigned  in  1  zero-extend loads when 1, else sign-extend.
- i_result  in  NB_DATA  ALU result / byte address.
- i_store_data  in  NB_DATA  rt value to store (already forwarded).
- i_write_reg  in  5  destination register.
- o_regWrite  out  1  registered.
- o_mem2reg  out  1  registered.
- o_write_reg  out  5  registered.
- o_wb_data  out  NB_DATA  registered writeback value.
- o_misaligned  out  1  registered, access faulted this instruction.
- o_halted  out  1  sticky halt flag.

Behaviour:
- Reset (i_rst=1 at edge): all outputs 0; all memory bytes cleared to 0; o_halted cleared.
- Address: idx = i_result[NB_ADDR-1:0]. Upper address bits are ignored, so addresses wrap modulo depth. Memory is byte-organised, little-endian.
- Alignment: half requires idx[0]=0; word requires idx[1:0]=00. A misaligned access with memRead or memWrite:
  - no memory write;
  - load data forced to 0;
  - o_misaligned=1 next cycle.
- Store: on the edge where i_memWrite=1, aligned, !i_stall, !i_halt, write:
  - byte: i_store_data[7:0] to idx;
  - half: i_store_data[15:0] to idx, idx+1;
  - word: i_store_data[31:0] to idx..idx+3.
- Load: combinational read of the current array, then extended:
  - byte: [7:0] sign/zero-extended;
  - half: [15:0] sign/zero-extended;
  - word: as read.
  - With i_memRead=0, load data = 0.
- Read and write to the same address in the same cycle: the load sees old contents (read-before-write).
- MEM/WB register: latency 1 cycle. On each non-stalled edge:
  - o_regWrite <= i_regWrite & !misaligned-load;
  - o_mem2reg <= i_mem2reg;
  - o_write_reg <= i_write_reg;
  - o_wb_data <= i_mem2reg ? load_data : i_result.
- Write to $0: o_regWrite is still passed through; the register file ignores it.
- i_stall=1: all registered outputs hold; no store. Stall and halt together behave as halt.
- i_halt=1: outputs hold; no store; o_halted <= 1. o_halted stays 1 until reset, even after i_halt deasserts. Normal operation resumes when i_halt=0.
- Reset asserted mid-stall or mid-halt: reset wins.

Optional Feature:
- Macro MEM_DEBUG_PORT_EN.
- Defined: adds ports i_dbg_addr (in, NB_ADDR) and o_dbg_data (out, NB_DATA). o_dbg_data is a registered word read at {i_dbg_addr[NB_ADDR-1:2],2'b00}, updated every cycle including during stall and halt. Reset value is 0. Used by the debug/UART unit to dump memory after halt.
- Not defined: the ports are absent and there is no extra logic.

Test Plan:
- Reset then SW 0xDEADBEEF at addr 0x10, then LW 0x10 (mem2reg=1, regWrite=1, rd=5) -> next cycle o_wb_data=0xDEADBEEF, o_write_reg=5, o_regWrite=1.
- SB 0x80 at 0x21, then LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080; LH 0x20 -> 0xFFFF8000.
- LW at 0x13 -> o_misaligned=1, o_wb_data=0, o_regWrite=0. SH at 0x13 -> memory unchanged; readback of 0x12 = prior value.
- i_stall=1 for 3 cycles during SW 0x55 to 0x30 -> outputs frozen, memory at 0x30 unchanged. Release stall -> store commits, outputs update after one edge.
- Non-memory R-type (mem2reg=0, i_result=0x1234) -> o_wb_data=0x1234 one cycle later. Address 0x100 with NB_ADDR=8 -> aliases 0x00.
- Pulse i_halt -> o_halted=1 sticky; i_rst=1 -> o_halted=0, all outputs 0, LW 0x10 returns 0.
